// File: rtl/mem_pkg.sv
// Shared types for the memory stage: op/size encodings, FSM states and size helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_RSVD  = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_1B = 2'b00,
        SZ_2B = 2'b01,
        SZ_4B = 2'b10,
        SZ_8B = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        WAIT  = 2'b10,
        DRAIN = 2'b11
    } state_t;

    function automatic logic [3:0] size_bytes(input mem_size_t sz);
        return 4'd1 << sz;
    endfunction

    function automatic logic [7:0] size_mask(input mem_size_t sz);
        logic [7:0] m;
        case (sz)
            SZ_1B:   m = 8'h01;
            SZ_2B:   m = 8'h03;
            SZ_4B:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: pick the addressed bytes out of the aligned word and zero/sign-extend them.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]        i_off,
    input  mem_size_t         i_size,
    input  logic              i_sext,
    input  logic [DATA_W-1:0] i_word,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SZ_1B:   o_data = {{(DATA_W-8){i_sext & w_shifted[7]}},   w_shifted[7:0]};
            SZ_2B:   o_data = {{(DATA_W-16){i_sext & w_shifted[15]}}, w_shifted[15:0]};
            SZ_4B:   o_data = {{(DATA_W-32){i_sext & w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: accepts one executed op per handshake, runs loads/stores on a req/resp port
// and emits a one-cycle writeback pulse. Handshake: an op is taken on a clock edge where
// exe_mem=1 and the stage is IDLE; mem_blocked (registered-state only) tells execute to hold.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exe_mem,
    input  logic [DATA_W-1:0] result,
    input  logic [31:0]       rflags,
    input  logic [1:0]        mem_op,
    input  logic [1:0]        mem_size,
    input  logic              mem_sext,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  dest_reg,
    output logic              mem_blocked,
    output logic              mem_req,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic [7:0]        mem_req_be,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_rflags,
    output logic              wb_fault,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

    logic              r_is_load;
    logic [2:0]        r_off;
    mem_size_t         r_size;
    logic              r_sext;
    logic [REG_W-1:0]  r_dest;
    logic [31:0]       r_rflags;

    logic              w_wb_valid, w_wb_we, w_wb_fault;
    logic [REG_W-1:0]  w_wb_dest;
    logic [DATA_W-1:0] w_wb_data;
    logic [31:0]       w_wb_rflags;

    mem_op_t           w_op;
    mem_size_t         w_size;
    logic              w_accept, w_is_mem, w_misalign;
    logic [DATA_W-1:0] w_load_data;

    assign w_op       = mem_op_t'(mem_op);
    assign w_size     = mem_size_t'(mem_size);
    assign w_accept   = exe_mem && (r_state == IDLE);
    assign w_is_mem   = (w_op == OP_LOAD) || (w_op == OP_STORE);
    assign w_misalign = ({1'b0, result[2:0]} + size_bytes(w_size)) > 4'd8;

    assign mem_blocked = (r_state != IDLE);
    assign mem_req     = (r_state == REQ);
    assign dbg_state   = r_state;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .i_off  (r_off),
        .i_size (r_size),
        .i_sext (r_sext),
        .i_word (mem_resp_data),
        .o_data (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Response is checked before the timeout so a reply in the last WAIT cycle still counts.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wb_valid  = 1'b0;
        w_wb_we     = 1'b0;
        w_wb_fault  = 1'b0;
        w_wb_dest   = r_dest;
        w_wb_data   = '0;
        w_wb_rflags = r_rflags;
        case (r_state)
            IDLE: begin
                w_wb_dest   = dest_reg;
                w_wb_rflags = rflags;
                if (exe_mem) begin
                    if (!w_is_mem) begin
                        w_wb_valid = 1'b1;
                        w_wb_we    = 1'b1;
                        w_wb_data  = result;
                    end else if (w_misalign) begin
                        w_wb_valid = 1'b1;
                        w_wb_fault = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (r_is_load) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_wb_valid  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = IDLE;
                    w_wb_valid  = 1'b1;
                    w_wb_we     = 1'b1;
                    w_wb_data   = w_load_data;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = DRAIN;
                    w_wb_valid  = 1'b1;
                    w_wb_fault  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (mem_resp_valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture happens only in IDLE, so the request payload is frozen for the whole REQ phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load    <= 1'b0;
            r_off        <= '0;
            r_size       <= SZ_1B;
            r_sext       <= 1'b0;
            r_dest       <= '0;
            r_rflags     <= '0;
            mem_req_we   <= 1'b0;
            mem_req_addr <= '0;
            mem_req_data <= '0;
            mem_req_be   <= '0;
        end else if (w_accept) begin
            r_is_load    <= (w_op == OP_LOAD);
            r_off        <= result[2:0];
            r_size       <= w_size;
            r_sext       <= mem_sext;
            r_dest       <= dest_reg;
            r_rflags     <= rflags;
            mem_req_we   <= (w_op == OP_STORE);
            mem_req_addr <= {result[DATA_W-1:3], 3'b000};
            mem_req_data <= store_data << {result[2:0], 3'b000};
            mem_req_be   <= size_mask(w_size) << result[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_fault  <= 1'b0;
            wb_dest   <= '0;
            wb_data   <= '0;
            wb_rflags <= '0;
        end else begin
            wb_valid  <= w_wb_valid;
            wb_we     <= w_wb_we;
            wb_fault  <= w_wb_fault;
            wb_dest   <= w_wb_valid ? w_wb_dest : '0;
            wb_data   <= w_wb_data;
            wb_rflags <= w_wb_valid ? w_wb_rflags : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of single-op vectors plus directed stall, timeout and reset sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exe_mem;
    logic [63:0] result;
    logic [31:0] rflags;
    logic [1:0]  mem_op;
    logic [1:0]  mem_size;
    logic        mem_sext;
    logic [63:0] store_data;
    logic [3:0]  dest_reg;
    logic        mem_blocked;
    logic        mem_req;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_data;
    logic [7:0]  mem_req_be;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
    logic        wb_valid;
    logic        wb_we;
    logic [3:0]  wb_dest;
    logic [63:0] wb_data;
    logic [31:0] wb_rflags;
    logic        wb_fault;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    mem_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .exe_mem        (exe_mem),
        .result         (result),
        .rflags         (rflags),
        .mem_op         (mem_op),
        .mem_size       (mem_size),
        .mem_sext       (mem_sext),
        .store_data     (store_data),
        .dest_reg       (dest_reg),
        .mem_blocked    (mem_blocked),
        .mem_req        (mem_req),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_be     (mem_req_be),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_dest        (wb_dest),
        .wb_data        (wb_data),
        .wb_rflags      (wb_rflags),
        .wb_fault       (wb_fault),
        .dbg_state      (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic        sext;
        logic [63:0] result;
        logic [63:0] sdata;
        logic [3:0]  dest;
        logic [31:0] rflags;
        logic [63:0] resp;
        int          lat;
        bit          req;
        bit          fault;
        bit          we;
        bit          chk_data;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] req_data;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(
        input logic [1:0] op, input logic [1:0] size, input logic sext,
        input logic [63:0] res, input logic [63:0] sdata, input logic [3:0] dest,
        input logic [31:0] fl, input logic [63:0] resp, input int lat,
        input bit req, input bit fault, input bit we, input bit chk_data,
        input logic [63:0] data, input logic [7:0] be, input logic [63:0] addr,
        input logic [63:0] req_data);
        vec_t v;
        v.op = op; v.size = size; v.sext = sext; v.result = res; v.sdata = sdata;
        v.dest = dest; v.rflags = fl; v.resp = resp; v.lat = lat; v.req = req;
        v.fault = fault; v.we = we; v.chk_data = chk_data; v.data = data;
        v.be = be; v.addr = addr; v.req_data = req_data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [1:0] size, input logic sext,
                            input logic [63:0] res, input logic [63:0] sdata,
                            input logic [3:0] dest, input logic [31:0] fl);
        exe_mem    = 1'b1;
        mem_op     = op;
        mem_size   = size;
        mem_sext   = sext;
        result     = res;
        store_data = sdata;
        dest_reg   = dest;
        rflags     = fl;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_blocked"}, mem_blocked, 0);
        chk({tag, "_req"},     mem_req, 0);
        chk({tag, "_req_we"},  mem_req_we, 0);
        chk({tag, "_addr"},    mem_req_addr, 0);
        chk({tag, "_rdata"},   mem_req_data, 0);
        chk({tag, "_be"},      mem_req_be, 0);
        chk({tag, "_wbv"},     wb_valid, 0);
        chk({tag, "_wbwe"},    wb_we, 0);
        chk({tag, "_wbdest"},  wb_dest, 0);
        chk({tag, "_wbdata"},  wb_data, 0);
        chk({tag, "_wbfl"},    wb_rflags, 0);
        chk({tag, "_wbfault"}, wb_fault, 0);
        chk({tag, "_state"},   dbg_state, 0);
    endtask

    // Ready and resp are held high throughout: resp outside WAIT must be ignored, and in REQ
    // only ready may act, giving load latency 3, store 2, NONE/fault 1.
    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        string t;
        t = $sformatf("v%0d", idx);
        drive_op(v.op, v.size, v.sext, v.result, v.sdata, v.dest, v.rflags);
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = v.resp;
        step();
        exe_mem = 1'b0;
        chk({t, "_req"}, mem_req, v.req);
        if (v.req) begin
            chk({t, "_blocked"}, mem_blocked, 1);
            chk({t, "_addr"},    mem_req_addr, v.addr);
            chk({t, "_be"},      mem_req_be, v.be);
            chk({t, "_req_we"},  mem_req_we, v.op == 2'b10);
            if (v.op == 2'b10) chk({t, "_rdata"}, mem_req_data, v.req_data);
        end
        lat = 1;
        while (!wb_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({t, "_lat"},     lat, v.lat);
        chk({t, "_wbv"},     wb_valid, 1);
        chk({t, "_wbwe"},    wb_we, v.we);
        chk({t, "_wbfault"}, wb_fault, v.fault);
        chk({t, "_wbdest"},  wb_dest, v.dest);
        chk({t, "_wbfl"},    wb_rflags, v.rflags);
        if (v.chk_data) chk({t, "_wbdata"}, wb_data, v.data);
        step();
        chk({t, "_pulse"},   wb_valid, 0);
        chk({t, "_idle"},    mem_blocked, 0);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        int n;
        bit stray;
        rst_n = 1'b0; exe_mem = 1'b0; result = '0; rflags = '0; mem_op = '0;
        mem_size = '0; mem_sext = 1'b0; store_data = '0; dest_reg = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // op size sext result sdata dest rflags resp | lat req fault we chkd data be addr reqdata
        vecs[0]  = mk(2'd0, 2'd0, 1'b0, 64'h1234, 64'h0, 4'd3, 32'hA5A50001, 64'h0,
                      1, 0, 0, 1, 1, 64'h1234, 8'h00, 64'h0, 64'h0);
        vecs[1]  = mk(2'd3, 2'd3, 1'b1, 64'hDEADBEEF00000001, 64'hFF, 4'd7, 32'h1, 64'hFFFF,
                      1, 0, 0, 1, 1, 64'hDEADBEEF00000001, 8'h00, 64'h0, 64'h0);
        vecs[2]  = mk(2'd1, 2'd2, 1'b1, 64'h1004, 64'h0, 4'd5, 32'h2, 64'h8000000000000000,
                      3, 1, 0, 1, 1, 64'hFFFFFFFF80000000, 8'hF0, 64'h1000, 64'h0);
        vecs[3]  = mk(2'd1, 2'd2, 1'b0, 64'h1004, 64'h0, 4'd5, 32'h3, 64'h8000000000000000,
                      3, 1, 0, 1, 1, 64'h0000000080000000, 8'hF0, 64'h1000, 64'h0);
        vecs[4]  = mk(2'd1, 2'd0, 1'b1, 64'h17, 64'h0, 4'd6, 32'h4, 64'h8100000000000000,
                      3, 1, 0, 1, 1, 64'hFFFFFFFFFFFFFF81, 8'h80, 64'h10, 64'h0);
        vecs[5]  = mk(2'd1, 2'd1, 1'b0, 64'h2, 64'h0, 4'd8, 32'h8, 64'h00000000F00D0000,
                      3, 1, 0, 1, 1, 64'hF00D, 8'h0C, 64'h0, 64'h0);
        vecs[6]  = mk(2'd1, 2'd3, 1'b1, 64'h3008, 64'h0, 4'd9, 32'h10, 64'h0123456789ABCDEF,
                      3, 1, 0, 1, 1, 64'h0123456789ABCDEF, 8'hFF, 64'h3008, 64'h0);
        vecs[7]  = mk(2'd1, 2'd3, 1'b0, 64'h1003, 64'h0, 4'd10, 32'h20, 64'h0,
                      1, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0);
        vecs[8]  = mk(2'd2, 2'd2, 1'b0, 64'h40, 64'h11223344, 4'd11, 32'h40, 64'h0,
                      2, 1, 0, 0, 0, 64'h0, 8'h0F, 64'h40, 64'h11223344);
        vecs[9]  = mk(2'd2, 2'd0, 1'b0, 64'h45, 64'hAB, 4'd12, 32'h80, 64'h0,
                      2, 1, 0, 0, 0, 64'h0, 8'h20, 64'h40, 64'h0000AB0000000000);
        vecs[10] = mk(2'd2, 2'd2, 1'b0, 64'h46, 64'h1, 4'd13, 32'h100, 64'h0,
                      1, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0);
        vecs[11] = mk(2'd1, 2'd1, 1'b0, 64'h7, 64'h0, 4'd14, 32'h200, 64'h0,
                      1, 0, 1, 0, 0, 64'h0, 8'h00, 64'h0, 64'h0);
        vecs[12] = mk(2'd1, 2'd2, 1'b1, 64'h8, 64'h0, 4'd15, 32'h400, 64'h000000007FFFFFFF,
                      3, 1, 0, 1, 1, 64'h7FFFFFFF, 8'h0F, 64'h8, 64'h0);

        // reset state
        step();
        step();
        chk_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // back-to-back NONE ops, one per cycle
        for (int i = 0; i < 3; i++) begin
            drive_op(2'd0, 2'd0, 1'b0, 64'h100 + 64'(i), 64'h0, 4'(i + 1), 32'h0);
            step();
            chk($sformatf("b2b%0d_wbv", i),   wb_valid, 1);
            chk($sformatf("b2b%0d_data", i),  wb_data, 64'h100 + 64'(i));
            chk($sformatf("b2b%0d_blk", i),   mem_blocked, 0);
        end
        exe_mem = 1'b0;
        step();

        // STORE 2B held for 3 stall cycles; next op waits behind it
        drive_op(2'd2, 2'd1, 1'b0, 64'h2002, 64'hBEEF, 4'd2, 32'hCAFE);
        step();
        drive_op(2'd0, 2'd0, 1'b0, 64'h55, 64'h0, 4'd9, 32'h99);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("st_req%0d", k),   mem_req, 1);
            chk($sformatf("st_we%0d", k),    mem_req_we, 1);
            chk($sformatf("st_addr%0d", k),  mem_req_addr, 64'h2000);
            chk($sformatf("st_be%0d", k),    mem_req_be, 8'h0C);
            chk($sformatf("st_data%0d", k),  mem_req_data, 64'hBEEF0000);
            chk($sformatf("st_blk%0d", k),   mem_blocked, 1);
            chk($sformatf("st_wbv%0d", k),   wb_valid, 0);
            if (k == 3) mem_req_ready = 1'b1;
            step();
        end
        mem_req_ready = 1'b0;
        chk("st_wbv",   wb_valid, 1);
        chk("st_wbwe",  wb_we, 0);
        chk("st_fault", wb_fault, 0);
        chk("st_fl",    wb_rflags, 32'hCAFE);
        chk("st_reqlo", mem_req, 0);
        chk("st_blk",   mem_blocked, 0);
        step();
        exe_mem = 1'b0;
        chk("nx_wbv",  wb_valid, 1);
        chk("nx_wbwe", wb_we, 1);
        chk("nx_data", wb_data, 64'h55);
        chk("nx_dest", wb_dest, 4'd9);
        chk("nx_fl",   wb_rflags, 32'h99);
        step();

        // LOAD timeout: fault after 255 WAIT cycles, late response drained
        drive_op(2'd1, 2'd3, 1'b0, 64'h100, 64'h0, 4'd4, 32'h77);
        step();
        exe_mem = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("to_state_wait", dbg_state, 2'd2);
        n = 0;
        while (!wb_valid && n < 400) begin
            step();
            n++;
        end
        chk("to_cycles", n, 255);
        chk("to_fault",  wb_fault, 1);
        chk("to_wbwe",   wb_we, 0);
        chk("to_fl",     wb_rflags, 32'h77);
        chk("to_blk",    mem_blocked, 1);
        chk("to_drain",  dbg_state, 2'd3);
        stray = 1'b0;
        while (n < 299) begin
            step();
            n++;
            if (wb_valid || !mem_blocked) stray = 1'b1;
        end
        chk("to_drain_hold", stray, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hFFFF_0000_FFFF_0000;
        step();
        mem_resp_valid = 1'b0;
        chk("to_release", mem_blocked, 0);
        chk("to_discard", wb_valid, 0);
        step();

        // asynchronous reset in the middle of WAIT
        drive_op(2'd1, 2'd2, 1'b0, 64'h2000, 64'h0, 4'd6, 32'h5);
        step();
        exe_mem = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(2'd0, 2'd0, 1'b0, 64'h4242, 64'h0, 4'd1, 32'h3);
        step();
        exe_mem = 1'b0;
        chk("post_wbv",  wb_valid, 1);
        chk("post_wbwe", wb_we, 1);
        chk("post_data", wb_data, 64'h4242);
        chk("post_dest", wb_dest, 4'd1);
        step();
        chk("post_pulse", wb_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
